// File: rtl/arbitration_pkg.sv
// Shared types and helpers for the arbitration client and its arbiter.
package arbitration_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        RELEASE = 2'd2
    } client_state_e;

    // Index width that never collapses to zero bits for a single-entry structure.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arbitration_client_if.sv
// Producer/arbiter-facing bundle of one arbitration client lane.
interface arbitration_client_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned PRIORITY_WIDTH = 2
);
    logic                      i_valid;
    logic                      o_ready;
    logic [DATA_WIDTH-1:0]     i_data;
    logic [PRIORITY_WIDTH-1:0] i_priority;
    logic                      o_request;
    logic [PRIORITY_WIDTH-1:0] o_priority;
    logic                      i_grant;
    logic                      o_issue;
    logic [DATA_WIDTH-1:0]     o_issue_data;

    // Producer and arbiter side.
    modport master (
        output i_valid, i_data, i_priority, i_grant,
        input  o_ready, o_request, o_priority, o_issue, o_issue_data
    );

    // Client side.
    modport slave (
        input  i_valid, i_data, i_priority, i_grant,
        output o_ready, o_request, o_priority, o_issue, o_issue_data
    );
endinterface

// File: rtl/arbitration_client_fifo.sv
// Generic synchronous FIFO: registered count, full/empty flags, head read-out.
module arbitration_client_fifo
    import arbitration_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       full,
    output logic                       empty,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = clog2_min1(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/arbitration_client.sv
// Requester agent for one arbiter lane: buffers commands, requests, issues on grant.
// Optional priority aging is enabled with ARBITRATION_CLIENT_AGING_EN.
module arbitration_client
    import arbitration_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned PRIORITY_WIDTH = 2,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned RELEASE_CYCLES = 0,
    parameter int unsigned AGE_CYCLES     = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    arbitration_client_if.slave   bus
);
    localparam int unsigned EW = PRIORITY_WIDTH + DATA_WIDTH;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned RW = 4;

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_REQUEST = REQUEST;
    localparam logic [1:0] ST_RELEASE = RELEASE;

    localparam logic [PRIORITY_WIDTH-1:0] PRIO_MAX = '1;

    logic [1:0]                state_q, state_d;
    logic [RW-1:0]             rel_q, rel_d;
    logic                      issue_q;
    logic [DATA_WIDTH-1:0]     issue_data_q;

    logic                      push, pop, full, empty, more;
    logic [EW-1:0]             head;
    logic [CW-1:0]             count;
    logic [PRIORITY_WIDTH-1:0] head_prio, eff_prio;
    logic [DATA_WIDTH-1:0]     head_data;

    assign push      = bus.i_valid & ~full;
    assign pop       = (state_q == ST_REQUEST) & bus.i_grant;
    assign head_prio = head[EW-1 -: PRIORITY_WIDTH];
    assign head_data = head[DATA_WIDTH-1:0];
    // Entries remaining after this cycle's pop, counting a concurrent push.
    assign more      = (count != CW'(1)) | push;

    arbitration_client_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.i_priority, bus.i_data}),
        .full  (full),
        .empty (empty),
        .head  (head),
        .count (count)
    );

    always_comb begin
        state_d = state_q;
        rel_d   = rel_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (bus.i_grant) begin
                    if (RELEASE_CYCLES > 0) begin
                        state_d = ST_RELEASE;
                        rel_d   = RW'(RELEASE_CYCLES) - RW'(1);
                    end else begin
                        state_d = more ? ST_REQUEST : ST_IDLE;
                    end
                end
            end
            ST_RELEASE: begin
                if (rel_q == '0) begin
                    state_d = empty ? ST_IDLE : ST_REQUEST;
                end else begin
                    rel_d = rel_q - RW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            rel_q        <= '0;
            issue_q      <= 1'b0;
            issue_data_q <= '0;
        end else begin
            state_q <= state_d;
            rel_q   <= rel_d;
            issue_q <= pop;
            if (pop) begin
                issue_data_q <= head_data;
            end
        end
    end

`ifdef ARBITRATION_CLIENT_AGING_EN
    localparam int unsigned WW = clog2_min1(AGE_CYCLES);

    logic [WW-1:0]             wait_q;
    logic [PRIORITY_WIDTH-1:0] boost_q;
    logic [PRIORITY_WIDTH:0]   prio_sum;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wait_q  <= '0;
            boost_q <= '0;
        end else if (state_q == ST_REQUEST) begin
            if (bus.i_grant) begin
                wait_q  <= '0;
                boost_q <= '0;
            end else if (wait_q == WW'(AGE_CYCLES - 1)) begin
                wait_q <= '0;
                if (boost_q != PRIO_MAX) begin
                    boost_q <= boost_q + PRIORITY_WIDTH'(1);
                end
            end else begin
                wait_q <= wait_q + WW'(1);
            end
        end
    end

    assign prio_sum = {1'b0, head_prio} + {1'b0, boost_q};
    assign eff_prio = prio_sum[PRIORITY_WIDTH] ? PRIO_MAX : prio_sum[PRIORITY_WIDTH-1:0];
`else
    assign eff_prio = head_prio;
`endif

    assign bus.o_ready      = ~full;
    assign bus.o_request    = (state_q == ST_REQUEST);
    assign bus.o_priority   = (state_q == ST_REQUEST) ? eff_prio : '0;
    assign bus.o_issue      = issue_q;
    assign bus.o_issue_data = issue_data_q;

endmodule

// File: tb/tb_arbitration_client.sv
// Directed bench for arbitration_client: one lane with no release gap, one with a 3-cycle gap.
module tb_arbitration_client;
    logic clk;
    logic rst_n;
    logic tie0, grant0, tie3, grant3;
    int   n_checks;
    int   n_fail;

    arbitration_client_if #(.DATA_WIDTH(32), .PRIORITY_WIDTH(2)) if0 ();
    arbitration_client_if #(.DATA_WIDTH(32), .PRIORITY_WIDTH(2)) if3 ();

    assign if0.i_grant = tie0 ? if0.o_request : grant0;
    assign if3.i_grant = tie3 ? if3.o_request : grant3;

    arbitration_client #(
        .DATA_WIDTH     (32),
        .PRIORITY_WIDTH (2),
        .DEPTH          (4),
        .RELEASE_CYCLES (0),
        .AGE_CYCLES     (8)
    ) u_dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if0)
    );

    arbitration_client #(
        .DATA_WIDTH     (32),
        .PRIORITY_WIDTH (2),
        .DEPTH          (4),
        .RELEASE_CYCLES (3),
        .AGE_CYCLES     (8)
    ) u_dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected priority of a head with stored priority p after k ungranted request cycles.
    function automatic int eff_prio(input int p, input int k);
`ifdef ARBITRATION_CLIENT_AGING_EN
        int v;
        v = p + k / 8;
        return (v > 3) ? 3 : v;
`else
        return p + 0 * k;
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_iss, first_iss, second_iss, low_cnt;
        logic [31:0] iss_data [2];
        logic req_again;

        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        tie0 = 1'b0; grant0 = 1'b0; tie3 = 1'b0; grant3 = 1'b0;
        if0.i_valid = 1'b0; if0.i_data = '0; if0.i_priority = '0;
        if3.i_valid = 1'b0; if3.i_data = '0; if3.i_priority = '0;
        tick();
        tick();
        check("rst_ready", if0.o_ready, 1);
        check("rst_request", if0.o_request, 0);
        check("rst_priority", if0.o_priority, 0);
        check("rst_issue", if0.o_issue, 0);
        check("rst_issue_data", if0.o_issue_data, 0);
        rst_n = 1'b1;

        // Fill, then reset with the FIFO full.
        for (int i = 0; i < 4; i++) begin
            if0.i_valid = 1'b1;
            if0.i_data = 32'hF0 + i;
            if0.i_priority = 2'(i);
            tick();
        end
        if0.i_valid = 1'b0;
        check("full_ready", if0.o_ready, 0);
        check("full_request", if0.o_request, 1);
        rst_n = 1'b0;
        tick();
        tick();
        check("rst2_ready", if0.o_ready, 1);
        check("rst2_request", if0.o_request, 0);
        check("rst2_issue", if0.o_issue, 0);
        rst_n = 1'b1;
        grant0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst2_stale_issue", if0.o_issue, 0);
            check("rst2_stale_req", if0.o_request, 0);
        end
        grant0 = 1'b0;

        // Single command, grant tied to request.
        tie0 = 1'b1;
        if0.i_valid = 1'b1; if0.i_data = 32'h11; if0.i_priority = 2'd1;
        tick();
        if0.i_valid = 1'b0;
        check("a_idle", if0.o_request, 0);
        tick();
        check("a_request", if0.o_request, 1);
        check("a_priority", if0.o_priority, 1);
        check("a_no_issue_yet", if0.o_issue, 0);
        tick();
        check("a_issue", if0.o_issue, 1);
        check("a_issue_data", if0.o_issue_data, 32'h11);
        check("a_back_idle", if0.o_request, 0);
        tick();
        check("a_issue_pulse", if0.o_issue, 0);
        tie0 = 1'b0;

        // Overfill: fifth push refused, then FIFO order on back-to-back grants.
        for (int i = 0; i < 5; i++) begin
            if0.i_valid = 1'b1;
            if0.i_data = 32'hA0 + i;
            if0.i_priority = 2'd2;
            check("fill_ready", if0.o_ready, (i < 4) ? 1 : 0);
            tick();
        end
        if0.i_valid = 1'b0;
        grant0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fifo_issue", if0.o_issue, 1);
            check("fifo_order", if0.o_issue_data, 32'hA0 + i);
        end
        grant0 = 1'b0;
        check("drained_request", if0.o_request, 0);
        tick();
        check("drained_issue", if0.o_issue, 0);

        // Grant withheld: request holds, priority ages only when aging is built.
        if0.i_valid = 1'b1; if0.i_data = 32'h55; if0.i_priority = 2'd0;
        tick();
        if0.i_data = 32'h66; if0.i_priority = 2'd1;
        tick();
        if0.i_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            check("hold_request", if0.o_request, 1);
            check("hold_priority", if0.o_priority, eff_prio(0, k));
            check("hold_no_issue", if0.o_issue, 0);
            if (k < 29) tick();
        end
        grant0 = 1'b1;
        tick();
        check("hold_issue", if0.o_issue, 1);
        check("hold_issue_data", if0.o_issue_data, 32'h55);
        check("next_request", if0.o_request, 1);
        check("next_priority", if0.o_priority, eff_prio(1, 0));
        tick();
        check("next_issue_data", if0.o_issue_data, 32'h66);
        check("next_idle", if0.o_request, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray_grant_issue", if0.o_issue, 0);
        end
        grant0 = 1'b0;

        // Release gap of 3 cycles between two issues.
        tie3 = 1'b1;
        if3.i_valid = 1'b1; if3.i_data = 32'h31; if3.i_priority = 2'd1;
        tick();
        if3.i_data = 32'h32;
        tick();
        if3.i_valid = 1'b0;
        n_iss = 0; first_iss = 0; second_iss = 0; low_cnt = 0; req_again = 1'b0;
        iss_data[0] = '0; iss_data[1] = '0;
        for (int c = 0; c < 30; c++) begin
            if (if3.o_issue) begin
                if (n_iss < 2) iss_data[n_iss] = if3.o_issue_data;
                if (n_iss == 0) first_iss = c;
                if (n_iss == 1) second_iss = c;
                n_iss++;
            end
            if (n_iss == 1 && !req_again) begin
                if (if3.o_request) req_again = 1'b1;
                else low_cnt++;
            end
            tick();
        end
        tie3 = 1'b0;
        check("rel_issue_count", n_iss, 2);
        check("rel_low_cycles", low_cnt, 3);
        check("rel_issue_gap", second_iss - first_iss, 4);
        check("rel_data0", iss_data[0], 32'h31);
        check("rel_data1", iss_data[1], 32'h32);
        check("rel_idle", if3.o_request, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
